// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-step controller feeding the snake body engine.
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   start           level; starts or restarts a game from IDLE/OVER
//   btn_*           debounced direction levels (priority right > up > left > down)
//   end_shift       pulse from snake: body traversal finished
//   self_col        snake self-collision flag
//   last_head       current head {x, y, active}
//   food_x, food_y  food cell
//   move            direction 0 right, 1 up, 2 left, 3 down
//   length          snake length
//   shift           one-cycle step pulse to snake
//   snake_rst       active-high reset to snake
//   food_req        one-cycle pulse: food eaten
//   score           foods eaten this game
//   state           0 IDLE, 1 RUN, 2 OVER
module snake_game_ctrl #(
    parameter int H        = 32,
    parameter int V        = 32,
    parameter int TICK     = 2500000,
    parameter int INIT_LEN = 6,
    parameter int WRAP     = 0,
    parameter int XB       = $clog2(H),
    parameter int YB       = $clog2(V),
    parameter int LB       = $clog2(H * V)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             btn_right,
    input  logic             btn_up,
    input  logic             btn_left,
    input  logic             btn_down,
    input  logic             end_shift,
    input  logic             self_col,
    input  logic [XB+YB:0]   last_head,
    input  logic [XB-1:0]    food_x,
    input  logic [YB-1:0]    food_y,
    output logic [1:0]       move,
    output logic [LB-1:0]    length,
    output logic             shift,
    output logic             snake_rst,
    output logic             food_req,
    output logic [15:0]      score,
    output logic [1:0]       state
);
    localparam int CB = TICK > 1 ? $clog2(TICK) : 1;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_SHIFT, S_CHECK, S_OVER} fsm_t;

    fsm_t          fsm;
    logic [1:0]    dir;
    logic [CB-1:0] cnt;
    logic [XB-1:0] hx;
    logic [YB-1:0] hy;
    logic [1:0]    cand;
    logic          cand_v, tick, wall, eat;
    logic          unused;

    assign hx     = last_head[XB+YB:YB+1];
    assign hy     = last_head[YB:1];
    assign unused = last_head[0];

    always_comb begin
        cand_v = btn_right | btn_up | btn_left | btn_down;
        cand   = btn_right ? 2'd0 : btn_up ? 2'd1 : btn_left ? 2'd2 : 2'd3;
        tick   = cnt == CB'(TICK - 1);
        wall   = WRAP == 0 && ((move == 2'd0 && hx == XB'(H - 1)) || (move == 2'd2 && hx == '0) ||
                               (move == 2'd1 && hy == YB'(V - 1)) || (move == 2'd3 && hy == '0));
        eat    = hx == food_x && hy == food_y;
    end

    always_ff @(posedge clk) begin
        shift    <= 1'b0;
        food_req <= 1'b0;
        if (!reset) begin
            fsm       <= S_IDLE;
            state     <= 2'd0;
            move      <= 2'd0;
            dir       <= 2'd0;
            length    <= LB'(INIT_LEN);
            score     <= '0;
            snake_rst <= 1'b1;
            cnt       <= '0;
        end else begin
            case (fsm)
                // Game values load on entry so INIT already presents the fresh game.
                S_IDLE, S_OVER: if (start) begin
                    fsm       <= S_INIT;
                    state     <= 2'd1;
                    move      <= 2'd0;
                    dir       <= 2'd0;
                    length    <= LB'(INIT_LEN);
                    score     <= '0;
                    snake_rst <= 1'b1;
                    cnt       <= '0;
                end
                S_INIT: begin
                    fsm       <= S_WAIT;
                    snake_rst <= 1'b0;
                end
                // On the tick cycle move is left alone so the committed and issued directions agree.
                S_WAIT: if (tick) begin
                    cnt <= '0;
                    if (wall) begin
                        fsm   <= S_OVER;
                        state <= 2'd2;
                    end else begin
                        shift <= 1'b1;
                        dir   <= move;
                        fsm   <= S_SHIFT;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    // Opposite directions differ by exactly 2.
                    if (cand_v && (cand ^ dir) != 2'd2) move <= cand;
                end
                S_SHIFT: if (end_shift) fsm <= S_CHECK;
                S_CHECK: if (self_col) begin
                    fsm   <= S_OVER;
                    state <= 2'd2;
                end else begin
                    fsm <= S_WAIT;
                    if (eat) begin
                        food_req <= 1'b1;
                        score    <= score == 16'hFFFF ? score : score + 1'b1;
                        length   <= length == LB'(H * V - 1) ? length : length + 1'b1;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: vector table, directed corner sequences and a randomized model check.
module tb_snake_game_ctrl;
    localparam int TICK = 8, INIT_LEN = 6, H = 32, V = 32;
    localparam int P_IDLE = 0, P_INIT = 1, P_WAIT = 2, P_SHIFT = 3, P_CHECK = 4, P_OVER = 5;

    logic clk = 0, reset = 0, start = 0, end_shift = 0, self_col = 0;
    logic btn_right = 0, btn_up = 0, btn_left = 0, btn_down = 0;
    logic [4:0] hx = 16, hy = 16, fx = 0, fy = 0;
    logic [10:0] last_head;
    logic [1:0] move, state, move_w, state_w, move_s, state_s;
    logic [9:0] length, length_w;
    logic [3:0] length_s;
    logic shift, snake_rst, food_req, shift_w, snake_rst_w, food_req_w, shift_s, snake_rst_s, food_req_s;
    logic [15:0] score, score_w, score_s;
    logic start_s = 0, end_shift_s = 0;

    assign last_head = {hx, hy, 1'b1};

    snake_game_ctrl #(.H(H), .V(V), .TICK(TICK), .INIT_LEN(INIT_LEN), .WRAP(0)) dut (
        .clk(clk), .reset(reset), .start(start), .btn_right(btn_right), .btn_up(btn_up),
        .btn_left(btn_left), .btn_down(btn_down), .end_shift(end_shift), .self_col(self_col),
        .last_head(last_head), .food_x(fx), .food_y(fy), .move(move), .length(length),
        .shift(shift), .snake_rst(snake_rst), .food_req(food_req), .score(score), .state(state));

    snake_game_ctrl #(.H(H), .V(V), .TICK(TICK), .INIT_LEN(INIT_LEN), .WRAP(1)) dutw (
        .clk(clk), .reset(reset), .start(start), .btn_right(btn_right), .btn_up(btn_up),
        .btn_left(btn_left), .btn_down(btn_down), .end_shift(end_shift), .self_col(self_col),
        .last_head(last_head), .food_x(fx), .food_y(fy), .move(move_w), .length(length_w),
        .shift(shift_w), .snake_rst(snake_rst_w), .food_req(food_req_w), .score(score_w), .state(state_w));

    snake_game_ctrl #(.H(4), .V(4), .TICK(2), .INIT_LEN(INIT_LEN), .WRAP(1)) duts (
        .clk(clk), .reset(reset), .start(start_s), .btn_right(1'b0), .btn_up(1'b0),
        .btn_left(1'b0), .btn_down(1'b0), .end_shift(end_shift_s), .self_col(1'b0),
        .last_head(5'b01011), .food_x(2'd1), .food_y(2'd1), .move(move_s), .length(length_s),
        .shift(shift_s), .snake_rst(snake_rst_s), .food_req(food_req_s), .score(score_s), .state(state_s));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] outs();
        return {state, move, length, shift, snake_rst, food_req, score};
    endfunction

    task automatic wait_shift(input string name);
        int k = 0;
        do begin step(); k++; end while (shift !== 1'b1 && k < 40);
        check(name, 64'(shift), 64'd1);
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic rst, st;
        logic [3:0] btn;
        logic es;
        logic [1:0] e_state, e_move;
        logic e_shift, e_srst;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic [3:0] b, logic e,
                                logic [1:0] st, logic [1:0] mv, logic sh, logic sr);
        vec_t v;
        v.rst = r; v.st = s; v.btn = b; v.es = e;
        v.e_state = st; v.e_move = mv; v.e_shift = sh; v.e_srst = sr;
        return v;
    endfunction

    // ---------------- reference model ----------------
    int ph = P_IDLE, waited = 0, m_move = 0, m_dir = 0, m_len = INIT_LEN, m_score = 0;
    logic m_shift = 0, m_srst = 1, m_food = 0;
    int dx[4] = '{1, 0, -1, 0};
    int dy[4] = '{0, 1, 0, -1};

    task automatic model();
        int nx, ny, c;
        logic [3:0] b;
        m_shift = 0;
        m_food  = 0;
        if (!reset) begin
            ph = P_IDLE; m_move = 0; m_len = INIT_LEN; m_score = 0; m_srst = 1; waited = 0;
            return;
        end
        case (ph)
            P_IDLE, P_OVER: if (start) begin
                ph = P_INIT; m_move = 0; m_dir = 0; m_len = INIT_LEN; m_score = 0; m_srst = 1; waited = 0;
            end
            P_INIT: begin ph = P_WAIT; m_srst = 0; end
            P_WAIT: begin
                waited++;
                if (waited == TICK) begin
                    waited = 0;
                    nx = int'(hx) + dx[m_move];
                    ny = int'(hy) + dy[m_move];
                    if (nx < 0 || nx >= H || ny < 0 || ny >= V) ph = P_OVER;
                    else begin m_shift = 1; m_dir = m_move; ph = P_SHIFT; end
                end else begin
                    b = {btn_down, btn_left, btn_up, btn_right};
                    c = -1;
                    for (int i = 3; i >= 0; i--) if (b[i]) c = i;
                    if (c >= 0 && c != (m_dir + 2) % 4) m_move = c;
                end
            end
            P_SHIFT: if (end_shift) ph = P_CHECK;
            P_CHECK: if (self_col) ph = P_OVER;
                else begin
                    ph = P_WAIT;
                    if (hx == fx && hy == fy) begin
                        m_food = 1;
                        if (m_score < 65535) m_score++;
                        if (m_len < H * V - 1) m_len++;
                    end
                end
            default: ph = P_IDLE;
        endcase
    endtask

    function automatic logic [32:0] m_outs();
        logic [1:0] s;
        s = ph == P_IDLE ? 2'd0 : ph == P_OVER ? 2'd2 : 2'd1;
        return {s, 2'(m_move), 10'(m_len), m_shift, m_srst, m_food, 16'(m_score)};
    endfunction

    function automatic logic [4:0] pick();
        int r = $urandom_range(0, 3);
        return r == 0 ? 5'd0 : r == 1 ? 5'd31 : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        vec_t tbl[$];
        int k;
        logic saw;
        localparam logic [3:0] R = 4'b1000, U = 4'b0100, L = 4'b0010, D = 4'b0001, N = 4'b0000;
        // reset, start, INIT, first WAIT period (left ignored, up taken), shift, SHIFTING, CHECK,
        // second WAIT period (down now opposite, right beats up), start ignored while running
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, N, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, N, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, N, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, N, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, L, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, N, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, U, 0, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, N, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, N, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 1, D, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, N, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, N, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, D, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, R | U, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, N, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, N, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, N, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, N, 0, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            start = tbl[i].st;
            {btn_right, btn_up, btn_left, btn_down} = tbl[i].btn;
            end_shift = tbl[i].es;
            step();
            check($sformatf("vec%0d", i), 64'(outs()),
                  64'({tbl[i].e_state, tbl[i].e_move, 10'd6, tbl[i].e_shift, tbl[i].e_srst, 1'b0, 16'd0}));
        end
        start = 0;
        {btn_right, btn_up, btn_left, btn_down} = N;

        // wall at right edge: WRAP=0 ends the game, WRAP=1 shifts
        end_shift = 1; step(); end_shift = 0;
        hx = 31; step();
        k = 0; saw = 0;
        do begin step(); saw |= shift; k++; end while (shift_w !== 1'b1 && k < 20);
        check("wrap_shift", 64'(shift_w), 64'd1);
        check("wall_no_shift", 64'(saw), 64'd0);
        check("wall_over", 64'(state), 64'd2);

        // food hit
        hx = 17; hy = 16;
        start = 1; step(); start = 0;
        check("restart_init", 64'(outs()), 64'({2'd1, 2'd0, 10'd6, 1'b0, 1'b1, 1'b0, 16'd0}));
        step();
        wait_shift("t4_shift");
        fx = 17; fy = 16;
        end_shift = 1; step(); end_shift = 0;
        check("t4_in_check", 64'(food_req), 64'd0);
        step();
        check("t4_eat", 64'(outs()), 64'({2'd1, 2'd0, 10'd7, 1'b0, 1'b0, 1'b1, 16'd1}));
        step();
        check("t4_pulse_end", 64'(outs()), 64'({2'd1, 2'd0, 10'd7, 1'b0, 1'b0, 1'b0, 16'd1}));

        // self collision beats food
        wait_shift("t5_shift");
        end_shift = 1; step(); end_shift = 0;
        self_col = 1; step(); self_col = 0;
        check("t5_selfcol", 64'(outs()), 64'({2'd2, 2'd0, 10'd7, 1'b0, 1'b0, 1'b0, 16'd1}));
        start = 1; step(); start = 0;
        check("t5_restart", 64'(outs()), 64'({2'd1, 2'd0, 10'd6, 1'b0, 1'b1, 1'b0, 16'd0}));
        step();

        // reset in the middle of SHIFTING
        wait_shift("t6_shift");
        step();
        reset = 0; step(); reset = 1;
        check("t6_reset", 64'(outs()), 64'({2'd0, 2'd0, 10'd6, 1'b0, 1'b1, 1'b0, 16'd0}));
        end_shift = 1; step(); end_shift = 0;
        check("t6_late_end_shift", 64'(outs()), 64'({2'd0, 2'd0, 10'd6, 1'b0, 1'b1, 1'b0, 16'd0}));

        // length saturation on a 4x4 field (max 15)
        start_s = 1; step(); start_s = 0;
        for (int i = 0; i < 12; i++) begin
            k = 0;
            do begin step(); k++; end while (shift_s !== 1'b1 && k < 20);
            check("sat_shift", 64'(shift_s), 64'd1);
            end_shift_s = 1; step(); end_shift_s = 0;
            step();
            check($sformatf("sat_eat%0d", i), 64'({length_s, score_s}),
                  64'({4'(7 + i > 15 ? 15 : 7 + i), 16'(i + 1)}));
        end

        // randomized run against the model
        reset = 0; step(); model();
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 199) != 0;
            start = $urandom_range(0, 19) == 0;
            {btn_right, btn_up, btn_left, btn_down} = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0;
            end_shift = $urandom_range(0, 3) == 0;
            self_col = $urandom_range(0, 9) == 0;
            hx = pick();
            hy = pick();
            if ($urandom_range(0, 1) == 1) begin fx = hx; fy = hy; end
            else begin fx = 5'($urandom); fy = 5'($urandom); end
            step();
            model();
            check($sformatf("rand%0d", i), 64'(outs()), 64'(m_outs()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Game-step controller directly upstream of the snake body engine.
- Latches player direction, paces the game with a step timer and issues one shift per step.
- Waits for the snake's end_shift, then evaluates wall, self and food collisions.
- Drives move, length and the snake's reset; reports score and game state.

Parameters:
H, 32, playfield width in cells (XB = logb2(H))
V, 32, playfield height in cells (YB = logb2(V))
TICK, 2500000, clock cycles between game steps
INIT_LEN, 6, length value loaded at game start
WRAP, 0, 1 = edges wrap around (no wall death); 0 = wall collision ends game

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  level; starts or restarts a game
btn_right, btn_up, btn_left, btn_down  in  1 each  debounced direction levels
end_shift  in  1  one-cycle pulse from snake: body traversal finished
self_col  in  1  snake self-collision flag
last_head  in  XB+YB+1  current head {x, y, active}
food_x  in  XB  food cell x
food_y  in  YB  food cell y
move  out  2  direction: 0 right, 1 up, 2 left, 3 down
length  out  logb2(H*V)  snake length
shift  out  1  one-cycle step pulse to snake
snake_rst  out  1  active-high reset to snake
food_req  out  1  one-cycle pulse: food eaten, place new food
score  out  16  foods eaten this game
state  out  2  0 IDLE, 1 RUN, 2 OVER

Behaviour:
- Reset (reset=0 at clk edge), all outputs: state=IDLE, move=0, length=INIT_LEN, shift=0, food_req=0, score=0, snake_rst=1, tick counter=0.
- Reset is honoured in every state, including mid-shift; the snake is held in reset via snake_rst.
- Internal FSM: IDLE, INIT, WAIT_TICK, SHIFTING, CHECK, OVER. The state output is IDLE for IDLE; RUN for INIT, WAIT_TICK, SHIFTING and CHECK; OVER for OVER.
- IDLE: snake_rst=1. On start=1, go to INIT.
- INIT: 1 cycle with snake_rst=1. Loads length=INIT_LEN, score=0, move=0, committed direction=right, tick counter=0. Then goes to WAIT_TICK, where snake_rst=0.
- WAIT_TICK:
  - Tick counter increments each cycle; the tick fires when count = TICK-1.
  - Button sampling, each cycle: candidate = first asserted of right > up > left > down.
  - move <= candidate unless candidate is the opposite of the committed direction; opposite candidates are ignored.
  - On tick, with WRAP=0, wall check uses the head x/y against move:
    - right and x = H-1: wall
    - left and x = 0: wall
    - up and y = V-1: wall
    - down and y = 0: wall
  - Wall hit: go to OVER; no shift is issued.
  - No wall hit: shift=1 for exactly 1 cycle, committed direction <= move, counter=0, go to SHIFTING.
- SHIFTING: move and length are frozen. The block waits for end_shift and has no timeout. end_shift goes to CHECK.
- CHECK: 1 cycle.
  - self_col=1: go to OVER. This has priority over food, so a simultaneous food hit scores nothing.
  - Else if head x,y = food_x,food_y: food_req=1 for 1 cycle; score+1, saturating at 16'hFFFF; length+1, saturating at H*V-1.
  - Length and score update in the same cycle as food_req.
  - Then go to WAIT_TICK.
- OVER: length and score are held and snake_rst=0, so the final snake stays visible. On start=1, go to INIT.
- start is ignored in WAIT_TICK, SHIFTING and CHECK.
- Latency: 1 tick step = TICK cycles in WAIT_TICK, plus the snake traversal time, plus 1 CHECK cycle.
- All outputs are registered.

Test Plan:
1. TICK=8, INIT_LEN=6; reset low 3 cycles, then start pulse -> state 0→1; snake_rst high through INIT, then low; first shift pulse exactly 8 cycles after entering WAIT_TICK; move=0.
2. move=0; assert btn_left during WAIT_TICK -> move stays 0. Assert btn_up -> move=1 and committed at the next shift. Then btn_down -> ignored. btn_up+btn_right together -> move=0.
3. WRAP=0, move=0, head x=31, y=16, tick fires -> no shift pulse; state=2 on the next cycle. Same head with WRAP=1 -> shift pulse issued.
4. Head=(17,16), food=(17,16), end_shift pulse -> one-cycle food_req; length 6→7; score 0→1; back to WAIT_TICK.
5. self_col=1 and head=food in the same CHECK -> state=2, food_req=0, score and length unchanged. Then start -> INIT, length=6, score=0.
6. reset low during SHIFTING, before end_shift -> next cycle state=0, snake_rst=1, shift=0, length=INIT_LEN; a late end_shift is ignored.
